// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks LOAD, whitening ARK, then NR rounds of
// SB/SR/MC/ARK (MC skipped in the last round), emitting one-hot stage enables.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int SB_LAT = 3
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_load,
  output logic       o_sb_active,
  output logic       o_sr_en,
  output logic       o_mc_en,
  output logic       o_ark_en,
  output logic       o_key_step,
  output logic       o_final,
  output logic [3:0] o_round,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT_ARK, S_SUB_BYTES,
    S_SHIFT_ROWS, S_MIX_COLUMNS, S_ADD_ROUND_KEY, S_DONE
  } state_e;

  localparam logic [3:0] NR_R = 4'(NR);
  localparam logic [2:0] SB_L = 3'(SB_LAT);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [2:0] cnt_q,   cnt_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    if (i_abort) begin
      // Abort wins everywhere; in IDLE it also swallows a coincident start.
      state_d = S_IDLE;
      round_d = 4'd0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          round_d = 4'd0;
          cnt_d   = 3'd0;
          if (i_start) state_d = S_LOAD;
        end
        S_LOAD:     state_d = S_INIT_ARK;
        S_INIT_ARK: begin
          state_d = S_SUB_BYTES;
          round_d = 4'd1;
          cnt_d   = 3'd1;
        end
        S_SUB_BYTES: begin
          if (cnt_q >= SB_L) begin
            state_d = S_SHIFT_ROWS;
            cnt_d   = 3'd0;
          end else begin
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_SHIFT_ROWS:  state_d = (round_q == NR_R) ? S_ADD_ROUND_KEY : S_MIX_COLUMNS;
        S_MIX_COLUMNS: state_d = S_ADD_ROUND_KEY;
        S_ADD_ROUND_KEY: begin
          if (round_q == NR_R) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SUB_BYTES;
            round_d = round_q + 4'd1;
            cnt_d   = 3'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          round_d = 4'd0;
        end
        default: begin
          state_d = S_IDLE;
          round_d = 4'd0;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_load      = 1'b0;
    o_sb_active = 1'b0;
    o_sr_en     = 1'b0;
    o_mc_en     = 1'b0;
    o_ark_en    = 1'b0;
    o_key_step  = 1'b0;
    o_done      = 1'b0;
    o_round     = round_q;
    o_final     = 1'b0;
    case (state_q)
      S_LOAD:          o_load   = 1'b1;
      S_INIT_ARK:      o_ark_en = 1'b1;
      S_SUB_BYTES: begin
        o_sb_active = 1'b1;
        o_key_step  = (cnt_q == 3'd1);
        o_final     = (round_q == NR_R);
      end
      S_SHIFT_ROWS: begin
        o_sr_en = 1'b1;
        o_final = (round_q == NR_R);
      end
      S_MIX_COLUMNS:   o_mc_en  = 1'b1;
      S_ADD_ROUND_KEY: begin
        o_ark_en = 1'b1;
        o_final  = (round_q == NR_R);
      end
      S_DONE:          o_done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default instance (NR=10, SB_LAT=3) and
// an NR=14, SB_LAT=1 instance, with hand-computed cycle timings and pulse counts.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_start = 1'b0, a_abort = 1'b0, b_start = 1'b0, b_abort = 1'b0;
  logic a_busy, a_load, a_sb, a_sr, a_mc, a_ark, a_key, a_final, a_done;
  logic b_busy, b_load, b_sb, b_sr, b_mc, b_ark, b_key, b_final, b_done;
  logic [3:0] a_round, b_round;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl u_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(a_start), .i_abort(a_abort),
    .o_busy(a_busy), .o_load(a_load), .o_sb_active(a_sb), .o_sr_en(a_sr),
    .o_mc_en(a_mc), .o_ark_en(a_ark), .o_key_step(a_key), .o_final(a_final),
    .o_round(a_round), .o_done(a_done));

  aes_round_ctrl #(.NR(14), .SB_LAT(1)) u_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(b_start), .i_abort(b_abort),
    .o_busy(b_busy), .o_load(b_load), .o_sb_active(b_sb), .o_sr_en(b_sr),
    .o_mc_en(b_mc), .o_ark_en(b_ark), .o_key_step(b_key), .o_final(b_final),
    .o_round(b_round), .o_done(b_done));

  logic sel = 1'b0;
  logic m_busy, m_load, m_sb, m_sr, m_mc, m_ark, m_key, m_final, m_done;
  logic [3:0] m_round;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_load  = sel ? b_load  : a_load;
  assign m_sb    = sel ? b_sb    : a_sb;
  assign m_sr    = sel ? b_sr    : a_sr;
  assign m_mc    = sel ? b_mc    : a_mc;
  assign m_ark   = sel ? b_ark   : a_ark;
  assign m_key   = sel ? b_key   : a_key;
  assign m_final = sel ? b_final : a_final;
  assign m_done  = sel ? b_done  : a_done;
  assign m_round = sel ? b_round : a_round;

  wire [12:0] a_vec = {a_busy, a_load, a_sb, a_sr, a_mc, a_ark, a_key, a_final, a_round, a_done};
  wire [12:0] b_vec = {b_busy, b_load, b_sb, b_sr, b_mc, b_ark, b_key, b_final, b_round, b_done};

  int errors = 0, checks = 0;
  int n_load, n_sb, n_sr, n_mc, n_ark, n_key, n_done, n_final;
  int final_bad, multi, round_max, round_bad, prev_round, done_cyc, load_cyc;
  logic last_mc, last_busy;
  logic [3:0] last_round;

  task automatic clr();
    n_load = 0; n_sb = 0; n_sr = 0; n_mc = 0; n_ark = 0; n_key = 0; n_done = 0;
    n_final = 0; final_bad = 0; multi = 0; round_max = 0; round_bad = 0;
    prev_round = 0; done_cyc = -1; load_cyc = -1;
  endtask

  // Sample the selected DUT at the falling edge, then move just past the next rising edge.
  task automatic tick();
    int nr_cur;
    nr_cur = sel ? 14 : 10;
    @(negedge clk);
    n_load += int'(m_load); n_sb += int'(m_sb); n_sr += int'(m_sr);
    n_mc += int'(m_mc); n_ark += int'(m_ark); n_key += int'(m_key);
    if (m_done) begin n_done++; done_cyc = cyc; end
    if (m_load) load_cyc = cyc;
    if (m_final) begin n_final++; if (int'(m_round) != nr_cur) final_bad++; end
    if (int'(m_round) > round_max) round_max = int'(m_round);
    if (int'(m_round) != prev_round && int'(m_round) != prev_round + 1 && m_round != 4'd0)
      round_bad++;
    prev_round = int'(m_round);
    if (int'(m_load) + int'(m_sb) + int'(m_sr) + int'(m_mc) + int'(m_ark) > 1) multi++;
    last_mc = m_mc; last_busy = m_busy; last_round = m_round;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_vec !== 13'd0) begin errors++; $display("FAIL reset_a: got %b want 0", a_vec); end
    checks++; if (b_vec !== 13'd0) begin errors++; $display("FAIL reset_b: got %b want 0", b_vec); end
    rst_n = 1'b1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    checks++; if ({a_busy, a_load} !== 2'b11) begin errors++; $display("FAIL reset_pre_load: got %b want 11", {a_busy, a_load}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_vec !== 13'd0) begin errors++; $display("FAIL reset_async: got %b want 0", a_vec); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int e0;
    sel = 1'b0; clr(); e0 = cyc;
    for (int c = 0; c < 80; c++) begin
      a_start = (c == 0 || c == 5 || c == 20 || c == 61 || c == 62);
      tick();
    end
    a_start = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL norm_done_cnt: got %0d want 1", n_done); end
    checks++; if (done_cyc - e0 != 62) begin errors++; $display("FAIL norm_latency: got %0d want 62", done_cyc - e0); end
    checks++; if (n_load != 1) begin errors++; $display("FAIL norm_load: got %0d want 1", n_load); end
    checks++; if (n_ark != 11) begin errors++; $display("FAIL norm_ark: got %0d want 11", n_ark); end
    checks++; if (n_key != 10) begin errors++; $display("FAIL norm_key: got %0d want 10", n_key); end
    checks++; if (n_sr != 10) begin errors++; $display("FAIL norm_sr: got %0d want 10", n_sr); end
    checks++; if (n_mc != 9) begin errors++; $display("FAIL norm_mc: got %0d want 9", n_mc); end
    checks++; if (n_sb != 30) begin errors++; $display("FAIL norm_sb: got %0d want 30", n_sb); end
    checks++; if (round_max != 10) begin errors++; $display("FAIL norm_round_max: got %0d want 10", round_max); end
    checks++; if (round_bad != 0) begin errors++; $display("FAIL norm_round_seq: got %0d bad steps want 0", round_bad); end
    checks++; if (n_final != 5 || final_bad != 0) begin errors++; $display("FAIL norm_final: got %0d cycles (%0d off-round) want 5 (0)", n_final, final_bad); end
    checks++; if (multi != 0) begin errors++; $display("FAIL norm_onehot: got %0d multi-hot cycles want 0", multi); end
    checks++; if (a_busy !== 1'b0 || a_round !== 4'd0) begin errors++; $display("FAIL norm_idle: got busy=%b round=%0d want 0/0", a_busy, a_round); end
  endtask

  task automatic test_back_to_back();
    int e0;
    sel = 1'b0; clr(); e0 = cyc;
    for (int c = 0; c < 140; c++) begin
      a_start = (c < 125);
      tick();
    end
    a_start = 1'b0;
    checks++; if (n_done != 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", n_done); end
    checks++; if (load_cyc - e0 != 64) begin errors++; $display("FAIL b2b_second_load: got %0d want 64", load_cyc - e0); end
    checks++; if (done_cyc - e0 != 125) begin errors++; $display("FAIL b2b_second_done: got %0d want 125", done_cyc - e0); end
    checks++; if (n_load != 2 || n_mc != 18) begin errors++; $display("FAIL b2b_counts: got load=%0d mc=%0d want 2/18", n_load, n_mc); end
  endtask

  task automatic test_abort();
    int e0, loads;
    sel = 1'b0; clr(); e0 = cyc;
    for (int c = 0; c < 32; c++) begin
      a_start = (c == 0);
      a_abort = (c == 31);
      tick();
    end
    a_abort = 1'b0;
    checks++; if (last_mc !== 1'b1 || last_round !== 4'd5) begin errors++; $display("FAIL abort_at_mc5: got mc=%b round=%0d want 1/5", last_mc, last_round); end
    tick();
    checks++; if (last_busy !== 1'b0 || last_round !== 4'd0) begin errors++; $display("FAIL abort_idle: got busy=%b round=%0d want 0/0", last_busy, last_round); end
    repeat (70) tick();
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
    loads = n_load;
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    a_start = 1'b0; a_abort = 1'b0;
    repeat (3) tick();
    checks++; if (n_load != loads || last_busy !== 1'b0) begin errors++; $display("FAIL abort_drops_start: got loads=%0d busy=%b want %0d/0", n_load, last_busy, loads); end
    clr(); e0 = cyc;
    for (int c = 0; c < 70; c++) begin
      a_start = (c == 0);
      tick();
    end
    checks++; if (n_done != 1 || done_cyc - e0 != 62 || n_ark != 11) begin errors++; $display("FAIL abort_rerun: got done=%0d lat=%0d ark=%0d want 1/62/11", n_done, done_cyc - e0, n_ark); end
  endtask

  task automatic test_async_reset();
    sel = 1'b0; clr();
    for (int c = 0; c < 16; c++) begin
      a_start = (c == 0);
      tick();
    end
    a_start = 1'b0;
    checks++; if (a_sb !== 1'b1 || a_round !== 4'd3) begin errors++; $display("FAIL arst_at_sb3: got sb=%b round=%0d want 1/3", a_sb, a_round); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_vec !== 13'd0) begin errors++; $display("FAIL arst_clear: got %b want 0", a_vec); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    checks++; if (n_done != 0 || last_busy !== 1'b0) begin errors++; $display("FAIL arst_no_done: got done=%0d busy=%b want 0/0", n_done, last_busy); end
  endtask

  task automatic test_nr14();
    int e0;
    sel = 1'b1; clr(); e0 = cyc;
    for (int c = 0; c < 70; c++) begin
      b_start = (c == 0);
      tick();
    end
    b_start = 1'b0;
    checks++; if (n_done != 1 || done_cyc - e0 != 58) begin errors++; $display("FAIL nr14_latency: got done=%0d lat=%0d want 1/58", n_done, done_cyc - e0); end
    checks++; if (n_mc != 13) begin errors++; $display("FAIL nr14_mc: got %0d want 13", n_mc); end
    checks++; if (n_sb != 14) begin errors++; $display("FAIL nr14_sb: got %0d want 14", n_sb); end
    checks++; if (round_max != 14) begin errors++; $display("FAIL nr14_round_max: got %0d want 14", round_max); end
    checks++; if (n_ark != 15 || n_key != 14 || n_sr != 14) begin errors++; $display("FAIL nr14_counts: got ark=%0d key=%0d sr=%0d want 15/14/14", n_ark, n_key, n_sr); end
    checks++; if (n_final != 3 || final_bad != 0 || multi != 0) begin errors++; $display("FAIL nr14_final: got final=%0d bad=%0d multi=%0d want 3/0/0", n_final, final_bad, multi); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_nr14();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
